// File: rtl/operand_fetch_pkg.sv
// Shared widths and operand-select encoding for the operand fetch stage.
// Optional macro OPFETCH_ZERO_REG_EN makes register 0 read as constant zero.
package operand_fetch_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 5;
    localparam int NREGS_DEF       = 1 << ADDR_W_DEF;
    localparam int STALL_CNT_W_DEF = 16;

    typedef enum logic {
        SEL_RF = 1'b0,
        SEL_WB = 1'b1
    } opsel_e;

    function automatic opsel_e fwd_sel(input logic hit);
        return hit ? SEL_WB : SEL_RF;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Valid/ready bundles: decoder -> operand fetch, and operand fetch -> EX.
// Master drives the payload and valid; slave drives ready.
interface opf_dec_if
    import operand_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_rs1;
    logic [ADDR_W-1:0] in_rs2;
    logic [ADDR_W-1:0] in_rd;
    logic              in_rd_wen;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
        input  in_ready
    );
    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_rd_wen,
        output in_ready
    );
endinterface

interface opf_ex_if
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_A;
    logic [DATA_W-1:0] out_B;
    logic [ADDR_W-1:0] out_rd;
    logic              out_rd_wen;

    modport master (
        output out_valid, out_A, out_B, out_rd, out_rd_wen,
        input  out_ready
    );
    modport slave (
        input  out_valid, out_A, out_B, out_rd, out_rd_wen,
        output out_ready
    );
endinterface

// File: rtl/operand_fetch_scoreboard.sv
// Per-register pending bits; a set and clear of one register in a cycle keeps it set.
// With OPFETCH_ZERO_REG_EN, register 0 can never become pending.
module reg_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              set_en,
    input  logic [ADDR_W-1:0] set_addr,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic [ADDR_W-1:0] waw_addr,
    output logic              pend1,
    output logic              pend2,
    output logic              pend_waw
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0] r_pending;
    logic [NREGS-1:0] w_next;

    always_comb begin
        w_next = r_pending;
        if (clr_en) w_next[clr_addr] = 1'b0;
        // set applied last: a new producer is outstanding
        if (set_en) w_next[set_addr] = 1'b1;
`ifdef OPFETCH_ZERO_REG_EN
        w_next[0] = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_pending <= '0;
        else       r_pending <= w_next;
    end

    assign pend1    = r_pending[rd_addr1];
    assign pend2    = r_pending[rd_addr2];
    assign pend_waw = r_pending[waw_addr];

endmodule

// File: rtl/operand_fetch.sv
// Decode-side register read with writeback forwarding and scoreboard stalls.
// Macro OPFETCH_ZERO_REG_EN hardwires register 0 to zero.
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int STALL_CNT_W = STALL_CNT_W_DEF
)(
    input  logic                   clk,
    input  logic                   reset,
    opf_dec_if.slave               dec,
    opf_ex_if.master               ex,
    output logic [ADDR_W-1:0]      PR1,
    output logic [ADDR_W-1:0]      PR2,
    input  logic [DATA_W-1:0]      RD1,
    input  logic [DATA_W-1:0]      RD2,
    input  logic                   wb_write,
    input  logic [ADDR_W-1:0]      wb_WR,
    input  logic [DATA_W-1:0]      wb_WD,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic w_rs1_z, w_rs2_z;
    logic w_fwd1, w_fwd2, w_wb_rd;
    logic w_pend1, w_pend2, w_pend_waw;
    logic w_raw1, w_raw2, w_waw;
    logic w_hazard, w_space, w_accept;
    opsel_e w_sel1, w_sel2;
    logic [DATA_W-1:0] w_opA, w_opB;

    logic                   r_out_valid;
    logic [DATA_W-1:0]      r_out_A;
    logic [DATA_W-1:0]      r_out_B;
    logic [ADDR_W-1:0]      r_out_rd;
    logic                   r_out_rd_wen;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

`ifdef OPFETCH_ZERO_REG_EN
    assign w_rs1_z = (dec.in_rs1 == '0);
    assign w_rs2_z = (dec.in_rs2 == '0);
`else
    assign w_rs1_z = 1'b0;
    assign w_rs2_z = 1'b0;
`endif

    assign PR1 = dec.in_rs1;
    assign PR2 = dec.in_rs2;

    // reg_file commits at the edge, so same-cycle writeback must bypass it
    assign w_fwd1  = wb_write && (wb_WR == dec.in_rs1) && !w_rs1_z;
    assign w_fwd2  = wb_write && (wb_WR == dec.in_rs2) && !w_rs2_z;
    assign w_wb_rd = wb_write && (wb_WR == dec.in_rd);
    assign w_sel1  = fwd_sel(w_fwd1);
    assign w_sel2  = fwd_sel(w_fwd2);

    assign w_opA = w_rs1_z ? '0 : ((w_sel1 == SEL_WB) ? wb_WD : RD1);
    assign w_opB = w_rs2_z ? '0 : ((w_sel2 == SEL_WB) ? wb_WD : RD2);

    reg_scoreboard #(.ADDR_W(ADDR_W)) u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (w_accept && dec.in_rd_wen),
        .set_addr (dec.in_rd),
        .clr_en   (wb_write),
        .clr_addr (wb_WR),
        .rd_addr1 (dec.in_rs1),
        .rd_addr2 (dec.in_rs2),
        .waw_addr (dec.in_rd),
        .pend1    (w_pend1),
        .pend2    (w_pend2),
        .pend_waw (w_pend_waw)
    );

    assign w_raw1   = w_pend1 && !w_fwd1;
    assign w_raw2   = w_pend2 && !w_fwd2;
    assign w_waw    = dec.in_rd_wen && w_pend_waw && !w_wb_rd;
    assign w_hazard = dec.in_valid && (w_raw1 || w_raw2 || w_waw);
    assign w_space  = !r_out_valid || ex.out_ready;
    assign w_accept = dec.in_valid && w_space && !w_hazard;

    assign dec.in_ready = w_space && !w_hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_A      <= '0;
            r_out_B      <= '0;
            r_out_rd     <= '0;
            r_out_rd_wen <= 1'b0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_A      <= w_opA;
            r_out_B      <= w_opB;
            r_out_rd     <= dec.in_rd;
            r_out_rd_wen <= dec.in_rd_wen;
        end else if (ex.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    // only hazard stalls count; back-pressure alone is not a hazard stall
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_hazard && w_space && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign ex.out_valid  = r_out_valid;
    assign ex.out_A      = r_out_A;
    assign ex.out_B      = r_out_B;
    assign ex.out_rd     = r_out_rd;
    assign ex.out_rd_wen = r_out_rd_wen;
    assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed-vector bench for operand_fetch: forwarding, hazards, back-pressure,
// scoreboard set-wins, zero register, counter saturation and async reset.
module tb_operand_fetch;

    logic        clk;
    logic        reset;
    logic [4:0]  pr1, pr2;
    logic [31:0] rd1, rd2;
    logic        wb_write;
    logic [4:0]  wb_wr;
    logic [31:0] wb_wd;
    logic [15:0] stall_cnt;

    int n_run;
    int n_fail;
    logic [15:0] exp_stall;

    opf_dec_if #(.ADDR_W(5)) dec ();
    opf_ex_if #(.DATA_W(32), .ADDR_W(5)) ex ();

    operand_fetch dut (
        .clk       (clk),
        .reset     (reset),
        .dec       (dec),
        .ex        (ex),
        .PR1       (pr1),
        .PR2       (pr2),
        .RD1       (rd1),
        .RD2       (rd2),
        .wb_write  (wb_write),
        .wb_WR     (wb_wr),
        .wb_WD     (wb_wd),
        .stall_cnt (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen,
                         input logic [31:0] a, input logic [31:0] b);
        dec.in_valid  = 1'b1;
        dec.in_rs1    = rs1;
        dec.in_rs2    = rs2;
        dec.in_rd     = rd;
        dec.in_rd_wen = wen;
        rd1 = a;
        rd2 = b;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        dec.in_valid = 1'b0;
        dec.in_rs1 = '0; dec.in_rs2 = '0; dec.in_rd = '0; dec.in_rd_wen = 1'b0;
        rd1 = '0; rd2 = '0;
        wb_write = 1'b0; wb_wr = '0; wb_wd = '0;
        ex.out_ready = 1'b1;
        exp_stall = '0;
        @(negedge clk);
        #1;
        n_run++; if (ex.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %b exp 0", ex.out_valid); end
        n_run++; if (ex.out_A !== 32'd0) begin n_fail++; $display("FAIL rst_A got %h exp 0", ex.out_A); end
        n_run++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_stall got %0d exp 0", stall_cnt); end
        reset = 1'b0;
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %b exp 1", dec.in_ready); end
        @(negedge clk);
    endtask

    task automatic test_issue;
        drive(5'd6, 5'd8, 5'd4, 1'b1, 32'd6, 32'd8);
        #1;
        n_run++; if (pr1 !== 5'd6) begin n_fail++; $display("FAIL issue_PR1 got %0d exp 6", pr1); end
        n_run++; if (pr2 !== 5'd8) begin n_fail++; $display("FAIL issue_PR2 got %0d exp 8", pr2); end
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL issue_ready got %b exp 1", dec.in_ready); end
        @(negedge clk);
        dec.in_valid = 1'b0;
        #1;
        n_run++; if (ex.out_valid !== 1'b1) begin n_fail++; $display("FAIL issue_valid got %b exp 1", ex.out_valid); end
        n_run++; if (ex.out_A !== 32'd6) begin n_fail++; $display("FAIL issue_A got %h exp 6", ex.out_A); end
        n_run++; if (ex.out_B !== 32'd8) begin n_fail++; $display("FAIL issue_B got %h exp 8", ex.out_B); end
        n_run++; if (ex.out_rd !== 5'd4) begin n_fail++; $display("FAIL issue_rd got %0d exp 4", ex.out_rd); end
        n_run++; if (ex.out_rd_wen !== 1'b1) begin n_fail++; $display("FAIL issue_wen got %b exp 1", ex.out_rd_wen); end
    endtask

    task automatic test_raw_fwd;
        drive(5'd4, 5'd8, 5'd9, 1'b0, 32'h111, 32'd8);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_run++; if (dec.in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_ready[%0d] got %b exp 0", i, dec.in_ready); end
            @(negedge clk);
        end
        exp_stall = 16'd3;
        #1;
        n_run++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL raw_stall got %0d exp %0d", stall_cnt, exp_stall); end
        n_run++; if (ex.out_valid !== 1'b0) begin n_fail++; $display("FAIL raw_drain got %b exp 0", ex.out_valid); end
        wb_write = 1'b1; wb_wr = 5'd4; wb_wd = 32'd31;
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_ready got %b exp 1", dec.in_ready); end
        @(negedge clk);
        dec.in_valid = 1'b0; wb_write = 1'b0;
        #1;
        n_run++; if (ex.out_valid !== 1'b1) begin n_fail++; $display("FAIL fwd_valid got %b exp 1", ex.out_valid); end
        n_run++; if (ex.out_A !== 32'd31) begin n_fail++; $display("FAIL fwd_A got %h exp 1f", ex.out_A); end
        n_run++; if (ex.out_B !== 32'd8) begin n_fail++; $display("FAIL fwd_B got %h exp 8", ex.out_B); end
        n_run++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL fwd_stall got %0d exp %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_backpressure;
        ex.out_ready = 1'b0;
        drive(5'd1, 5'd2, 5'd3, 1'b0, 32'hAA, 32'hBB);
        for (int i = 0; i < 2; i++) begin
            #1;
            n_run++; if (dec.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d] got %b exp 0", i, dec.in_ready); end
            @(negedge clk);
            #1;
            n_run++; if (ex.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", i, ex.out_valid); end
            n_run++; if (ex.out_A !== 32'd31) begin n_fail++; $display("FAIL bp_A[%0d] got %h exp 1f", i, ex.out_A); end
            n_run++; if (ex.out_B !== 32'd8) begin n_fail++; $display("FAIL bp_B[%0d] got %h exp 8", i, ex.out_B); end
        end
        n_run++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL bp_stall got %0d exp %0d", stall_cnt, exp_stall); end
        ex.out_ready = 1'b1;
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b exp 1", dec.in_ready); end
        @(negedge clk);
        dec.in_valid = 1'b0;
        #1;
        n_run++; if (ex.out_A !== 32'hAA) begin n_fail++; $display("FAIL bp_newA got %h exp aa", ex.out_A); end
        n_run++; if (ex.out_B !== 32'hBB) begin n_fail++; $display("FAIL bp_newB got %h exp bb", ex.out_B); end
        n_run++; if (ex.out_rd !== 5'd3) begin n_fail++; $display("FAIL bp_rd got %0d exp 3", ex.out_rd); end
        n_run++; if (ex.out_rd_wen !== 1'b0) begin n_fail++; $display("FAIL bp_wen got %b exp 0", ex.out_rd_wen); end
    endtask

    task automatic test_set_wins;
        drive(5'd1, 5'd2, 5'd7, 1'b1, 32'd1, 32'd2);
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL sw_first got %b exp 1", dec.in_ready); end
        @(negedge clk);
        #1;
        n_run++; if (dec.in_ready !== 1'b0) begin n_fail++; $display("FAIL sw_waw got %b exp 0", dec.in_ready); end
        @(negedge clk);
        exp_stall = exp_stall + 16'd1;
        wb_write = 1'b1; wb_wr = 5'd7; wb_wd = 32'd5;
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL sw_same_cycle got %b exp 1", dec.in_ready); end
        @(negedge clk);
        wb_write = 1'b0;
        drive(5'd7, 5'd2, 5'd7, 1'b0, 32'h99, 32'd2);
        #1;
        n_run++; if (dec.in_ready !== 1'b1 && 1'b0) begin end
        n_run++; if (dec.in_ready !== 1'b0) begin n_fail++; $display("FAIL sw_still_pending got %b exp 0", dec.in_ready); end
        @(negedge clk);
        exp_stall = exp_stall + 16'd1;
        #1;
        n_run++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL sw_stall got %0d exp %0d", stall_cnt, exp_stall); end
        wb_write = 1'b1; wb_wr = 5'd7; wb_wd = 32'h77;
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL sw_clear_ready got %b exp 1", dec.in_ready); end
        @(negedge clk);
        wb_write = 1'b0;
        #1;
        n_run++; if (ex.out_A !== 32'h77) begin n_fail++; $display("FAIL sw_fwdA got %h exp 77", ex.out_A); end
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL sw_cleared got %b exp 1", dec.in_ready); end
        @(negedge clk);
        dec.in_valid = 1'b0;
        #1;
        n_run++; if (ex.out_A !== 32'h99) begin n_fail++; $display("FAIL sw_rfA got %h exp 99", ex.out_A); end
    endtask

    task automatic test_zero_reg;
        drive(5'd1, 5'd2, 5'd0, 1'b1, 32'd1, 32'd2);
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL z_wr0 got %b exp 1", dec.in_ready); end
        @(negedge clk);
        drive(5'd0, 5'd2, 5'd3, 1'b0, 32'hDEADBEEF, 32'd2);
`ifdef OPFETCH_ZERO_REG_EN
        wb_write = 1'b1; wb_wr = 5'd0; wb_wd = 32'h55;
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL z_ready got %b exp 1", dec.in_ready); end
        @(negedge clk);
        dec.in_valid = 1'b0; wb_write = 1'b0;
        #1;
        n_run++; if (ex.out_A !== 32'd0) begin n_fail++; $display("FAIL z_A got %h exp 0", ex.out_A); end
`else
        #1;
        n_run++; if (dec.in_ready !== 1'b0) begin n_fail++; $display("FAIL z_stall got %b exp 0", dec.in_ready); end
        @(negedge clk);
        exp_stall = exp_stall + 16'd1;
        wb_write = 1'b1; wb_wr = 5'd0; wb_wd = 32'h55;
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL z_ready got %b exp 1", dec.in_ready); end
        @(negedge clk);
        dec.in_valid = 1'b0; wb_write = 1'b0;
        #1;
        n_run++; if (ex.out_A !== 32'h55) begin n_fail++; $display("FAIL z_A got %h exp 55", ex.out_A); end
`endif
        n_run++; if (stall_cnt !== exp_stall) begin n_fail++; $display("FAIL z_stallcnt got %0d exp %0d", stall_cnt, exp_stall); end
    endtask

    task automatic test_saturate;
        drive(5'd1, 5'd2, 5'd13, 1'b1, 32'd1, 32'd2);
        @(negedge clk);
        drive(5'd13, 5'd2, 5'd3, 1'b0, 32'd0, 32'd2);
        repeat (65540) @(negedge clk);
        #1;
        n_run++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_cnt got %h exp ffff", stall_cnt); end
        n_run++; if (dec.in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_ready got %b exp 0", dec.in_ready); end
        wb_write = 1'b1; wb_wr = 5'd13; wb_wd = 32'h1313;
        @(negedge clk);
        dec.in_valid = 1'b0; wb_write = 1'b0;
        #1;
        n_run++; if (stall_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h exp ffff", stall_cnt); end
        n_run++; if (ex.out_A !== 32'h1313) begin n_fail++; $display("FAIL sat_A got %h exp 1313", ex.out_A); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        ex.out_ready = 1'b1;
        drive(5'd1, 5'd2, 5'd12, 1'b1, 32'h12, 32'd2);
        @(negedge clk);
        dec.in_valid = 1'b0;
        ex.out_ready = 1'b0;
        #1;
        n_run++; if (ex.out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_pre got %b exp 1", ex.out_valid); end
        #2;
        reset = 1'b1;
        #1;
        n_run++; if (ex.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_valid got %b exp 0", ex.out_valid); end
        n_run++; if (ex.out_A !== 32'd0) begin n_fail++; $display("FAIL rm_A got %h exp 0", ex.out_A); end
        n_run++; if (ex.out_rd !== 5'd0) begin n_fail++; $display("FAIL rm_rd got %0d exp 0", ex.out_rd); end
        n_run++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_stall got %0d exp 0", stall_cnt); end
        @(negedge clk);
        reset = 1'b0;
        drive(5'd12, 5'd12, 5'd12, 1'b1, 32'h3C, 32'h3C);
        #1;
        n_run++; if (dec.in_ready !== 1'b1) begin n_fail++; $display("FAIL rm_post_ready got %b exp 1", dec.in_ready); end
        @(negedge clk);
        dec.in_valid = 1'b0;
        #1;
        n_run++; if (ex.out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_post_valid got %b exp 1", ex.out_valid); end
        n_run++; if (ex.out_A !== 32'h3C) begin n_fail++; $display("FAIL rm_post_A got %h exp 3c", ex.out_A); end
        n_run++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_post_stall got %0d exp 0", stall_cnt); end
    endtask

    initial begin
        n_run  = 0;
        n_fail = 0;
        test_reset;
        test_issue;
        test_raw_fwd;
        test_backpressure;
        test_set_wins;
        test_zero_reg;
        test_saturate;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
